// File: rtl/snitch_icache_pkg.sv
// Shared FSM type, tag entry layout and parity helper for the icache tag array.
// Parity support is compiled in when SNITCH_ICACHE_TAG_PARITY_EN is defined.
package snitch_icache_pkg;

   typedef enum logic [1:0] {
      TAG_INIT  = 2'd0,
      TAG_IDLE  = 2'd1,
      TAG_FLUSH = 2'd2
   } tag_state_e;

   // Entry layout, LSB first: valid, err, tag, then the optional parity bit on top.
   localparam int unsigned ENTRY_VALID_BIT = 0;
   localparam int unsigned ENTRY_ERR_BIT   = 1;
   localparam int unsigned ENTRY_TAG_LSB   = 2;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
   localparam int unsigned ENTRY_PARITY_BITS = 1;
`else
   localparam int unsigned ENTRY_PARITY_BITS = 0;
`endif
   localparam int unsigned PARITY_MAX_W = 256;

   function automatic int unsigned entry_width(input int unsigned tag_width);
      return tag_width + 2 + ENTRY_PARITY_BITS;
   endfunction

   // Even parity over a zero-extended vector; 0 means a consistent entry when the bit is included.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/snitch_icache_tag_way.sv
// One tag way: its SRAM plus the hit/parity compare against the registered lookup tag.
// Parity checking is active when SNITCH_ICACHE_TAG_PARITY_EN is defined.
module snitch_icache_tag_way
   import snitch_icache_pkg::*;
#(
   parameter int unsigned LINE_COUNT     = 128,
   parameter int unsigned TAG_WIDTH      = 20,
   parameter type         sram_cfg_tag_t = logic,
   localparam int unsigned COUNT_ALIGN   = $clog2(LINE_COUNT),
   localparam int unsigned ENTRY_W       = entry_width(TAG_WIDTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  sram_cfg_tag_t          sram_cfg_i,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [COUNT_ALIGN-1:0] addr_i,
   input  logic [ENTRY_W-1:0]     wdata_i,
   input  logic [TAG_WIDTH-1:0]   lookup_tag_i,
   output logic                   hit_o,
   output logic                   err_o,
   output logic                   perr_o
);

   logic [ENTRY_W-1:0] rdata;
   logic               valid, tag_match, mismatch;

   tc_sram_impl #(
      .NumWords  (LINE_COUNT),
      .DataWidth (ENTRY_W),
      .impl_in_t (sram_cfg_tag_t)
   ) i_sram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .impl_i  (sram_cfg_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata)
   );

   assign valid     = rdata[ENTRY_VALID_BIT];
   assign tag_match = rdata[ENTRY_TAG_LSB +: TAG_WIDTH] == lookup_tag_i;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
   assign mismatch  = even_parity(PARITY_MAX_W'(rdata));
`else
   assign mismatch  = 1'b0;
`endif

   assign hit_o  = valid & tag_match & ~mismatch;
   assign err_o  = rdata[ENTRY_ERR_BIT];
   assign perr_o = valid & mismatch;

endmodule

// File: rtl/tc_sram_impl.sv
// Single-port SRAM model, one-cycle read latency; read data holds until the next read.
// The implementation config input is accepted for interface compatibility only.
module tc_sram_impl #(
   parameter int unsigned NumWords  = 32'd128,
   parameter int unsigned DataWidth = 32'd32,
   parameter type         impl_in_t = logic
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  impl_in_t                    impl_i,
   input  logic                        req_i,
   input  logic                        we_i,
   input  logic [$clog2(NumWords)-1:0] addr_i,
   input  logic [DataWidth-1:0]        wdata_i,
   output logic [DataWidth-1:0]        rdata_o
);

   logic [DataWidth-1:0] mem_q [NumWords];
   logic [DataWidth-1:0] rdata_q, rdata_d;
   impl_in_t             unused_cfg;

   assign unused_cfg = impl_i;

   always_ff @(posedge clk_i) begin
      if (req_i && we_i) mem_q[addr_i] <= wdata_i;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (req_i && !we_i) rdata_d = mem_q[addr_i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/snitch_icache_tag_array.sv
// Icache tag store: per-way SRAMs, lookup hit/way compare, invalidation sweep after reset and on flush.
// Optional entry parity via SNITCH_ICACHE_TAG_PARITY_EN.
module snitch_icache_tag_array
   import snitch_icache_pkg::*;
#(
   parameter int unsigned WAY_COUNT      = 4,
   parameter int unsigned LINE_COUNT     = 128,
   parameter int unsigned TAG_WIDTH      = 20,
   parameter type         sram_cfg_tag_t = logic,
   localparam int unsigned COUNT_ALIGN   = $clog2(LINE_COUNT),
   localparam int unsigned WAY_IDX       = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  sram_cfg_tag_t          sram_cfg_tag_i,
   input  logic                   lookup_valid_i,
   output logic                   lookup_ready_o,
   input  logic [COUNT_ALIGN-1:0] lookup_addr_i,
   input  logic [TAG_WIDTH-1:0]   lookup_tag_i,
   output logic                   result_valid_o,
   output logic                   result_hit_o,
   output logic [WAY_COUNT-1:0]   result_way_o,
   output logic                   result_err_o,
   output logic                   parity_err_o,
   input  logic                   write_valid_i,
   output logic                   write_ready_o,
   input  logic [COUNT_ALIGN-1:0] write_addr_i,
   input  logic [WAY_IDX-1:0]     write_way_i,
   input  logic [TAG_WIDTH-1:0]   write_tag_i,
   input  logic                   write_err_i,
   input  logic                   flush_valid_i,
   output logic                   flush_ready_o,
   output logic                   busy_o
);

   localparam int unsigned           ENTRY_W  = entry_width(TAG_WIDTH);
   localparam logic [COUNT_ALIGN-1:0] LAST_SET = COUNT_ALIGN'(LINE_COUNT - 1);

   tag_state_e             state_q, state_d;
   logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;
   logic                   rvalid_q, rvalid_d;
   logic [TAG_WIDTH-1:0]   ltag_q, ltag_d;
   logic                   sweep, write_acc, lookup_acc;
   logic [COUNT_ALIGN-1:0] sram_addr;
   logic [ENTRY_W-2-ENTRY_PARITY_BITS+1:0] payload;
   logic [ENTRY_W-1:0]     wentry, sram_wdata;
   logic [WAY_COUNT-1:0]   way_req, way_hit, way_err, way_perr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= TAG_INIT;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         ltag_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         ltag_q   <= ltag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         TAG_INIT, TAG_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) begin
               state_d = TAG_IDLE;
               cnt_d   = '0;
            end
         end
         TAG_IDLE: begin
            if (flush_valid_i) begin
               state_d = TAG_FLUSH;
               cnt_d   = '0;
            end
         end
         default: state_d = TAG_INIT;
      endcase
   end

   // Fixed priority in IDLE: flush, then write, then lookup.
   always_comb begin
      flush_ready_o  = (state_q == TAG_IDLE);
      write_ready_o  = flush_ready_o & ~flush_valid_i;
      lookup_ready_o = write_ready_o & ~write_valid_i;
      busy_o         = ~flush_ready_o;
   end

   assign sweep      = (state_q != TAG_IDLE);
   assign write_acc  = write_valid_i & write_ready_o;
   assign lookup_acc = lookup_valid_i & lookup_ready_o;

   always_comb begin
      rvalid_d   = lookup_acc;
      ltag_d     = lookup_acc ? lookup_tag_i : ltag_q;
      sram_addr  = sweep ? cnt_q : (write_acc ? write_addr_i : lookup_addr_i);
      payload    = {write_tag_i, write_err_i, 1'b1};
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
      wentry     = {even_parity(PARITY_MAX_W'(payload)), payload};
`else
      wentry     = payload;
`endif
      sram_wdata = sweep ? '0 : wentry;
   end

   for (genvar i = 0; i < WAY_COUNT; i++) begin : g_way
      assign way_req[i] = sweep | lookup_acc | (write_acc & (write_way_i == WAY_IDX'(i)));

      snitch_icache_tag_way #(
         .LINE_COUNT     (LINE_COUNT),
         .TAG_WIDTH      (TAG_WIDTH),
         .sram_cfg_tag_t (sram_cfg_tag_t)
      ) i_way (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .sram_cfg_i   (sram_cfg_tag_i),
         .req_i        (way_req[i]),
         .we_i         (sweep | write_acc),
         .addr_i       (sram_addr),
         .wdata_i      (sram_wdata),
         .lookup_tag_i (ltag_q),
         .hit_o        (way_hit[i]),
         .err_o        (way_err[i]),
         .perr_o       (way_perr[i])
      );
   end

   // Descending scan so the lowest hitting way is the one that sticks.
   always_comb begin
      result_valid_o = rvalid_q;
      result_hit_o   = 1'b0;
      result_way_o   = '0;
      result_err_o   = 1'b0;
      parity_err_o   = 1'b0;
      if (rvalid_q) begin
         for (int i = WAY_COUNT - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
               result_way_o    = '0;
               result_way_o[i] = 1'b1;
               result_err_o    = way_err[i];
               result_hit_o    = 1'b1;
            end
         end
         parity_err_o = |way_perr;
      end
   end

endmodule

// File: tb/tb_snitch_icache_tag_array.sv
// Directed bench for snitch_icache_tag_array (4 ways, 8 sets, 20-bit tags) with a result scoreboard.
module tb_snitch_icache_tag_array;

   typedef struct packed {
      logic       hit;
      logic [3:0] way;
      logic       err;
      logic       perr;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        lookup_valid, lookup_ready;
   logic [2:0]  lookup_addr;
   logic [19:0] lookup_tag;
   logic        result_valid, result_hit, result_err, parity_err;
   logic [3:0]  result_way;
   logic        write_valid, write_ready;
   logic [2:0]  write_addr;
   logic [1:0]  write_way;
   logic [19:0] write_tag;
   logic        write_err;
   logic        flush_valid, flush_ready;
   logic        busy;

   int   total = 0;
   int   bad   = 0;
   res_t sb[$];

   logic [19:0] m_tag [8][4];
   logic        m_val [8][4];
   logic        m_err [8][4];

   snitch_icache_tag_array #(
      .WAY_COUNT  (4),
      .LINE_COUNT (8),
      .TAG_WIDTH  (20)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .sram_cfg_tag_i (1'b0),
      .lookup_valid_i (lookup_valid),
      .lookup_ready_o (lookup_ready),
      .lookup_addr_i  (lookup_addr),
      .lookup_tag_i   (lookup_tag),
      .result_valid_o (result_valid),
      .result_hit_o   (result_hit),
      .result_way_o   (result_way),
      .result_err_o   (result_err),
      .parity_err_o   (parity_err),
      .write_valid_i  (write_valid),
      .write_ready_o  (write_ready),
      .write_addr_i   (write_addr),
      .write_way_i    (write_way),
      .write_tag_i    (write_tag),
      .write_err_i    (write_err),
      .flush_valid_i  (flush_valid),
      .flush_ready_o  (flush_ready),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model;
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 4; w++) begin
            m_val[s][w] = 1'b0;
            m_tag[s][w] = '0;
            m_err[s][w] = 1'b0;
         end
   endtask

   function automatic res_t model_lookup(input int s, input logic [19:0] t);
      res_t r;
      r = '0;
      for (int w = 3; w >= 0; w--)
         if (m_val[s][w] && m_tag[s][w] == t) begin
            r.hit = 1'b1;
            r.way = 4'(1 << w);
            r.err = m_err[s][w];
         end
      return r;
   endfunction

   task automatic do_write(input int s, input int w, input logic [19:0] t, input logic e);
      write_valid = 1'b1;
      write_addr  = 3'(s);
      write_way   = 2'(w);
      write_tag   = t;
      write_err   = e;
      #1;
      chk("write_ready", write_ready, 1);
      cyc;
      write_valid = 1'b0;
      m_val[s][w] = 1'b1;
      m_tag[s][w] = t;
      m_err[s][w] = e;
   endtask

   task automatic do_lookup(input int s, input logic [19:0] t);
      lookup_valid = 1'b1;
      lookup_addr  = 3'(s);
      lookup_tag   = t;
      #1;
      chk("lookup_ready", lookup_ready, 1);
      sb.push_back(model_lookup(s, t));
      cyc;
      lookup_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_readies"}, {flush_ready, write_ready, lookup_ready}, 0);
      chk({tag, "_result"}, {result_valid, result_hit, result_way, result_err, parity_err}, 0);
   endtask

   task automatic wait_init(input string tag);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) chk({tag, "_ready_low"}, lookup_ready, 0);
         cyc;
         chk({tag, "_busy"}, busy, (k < 8));
      end
      chk({tag, "_ready_high"}, lookup_ready, 1);
   endtask

   // Results appear for exactly the cycle after acceptance; sample mid-cycle.
   always @(negedge clk) begin : mon
      res_t e;
      if (result_valid) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            e = sb.pop_front();
            chk("res_hit", result_hit, e.hit);
            chk("res_way", result_way, e.way);
            chk("res_err", result_err, e.err);
            chk("res_perr", parity_err, e.perr);
         end
      end else begin
         chk("idle_result_zero", {result_hit, result_way, result_err, parity_err}, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] b2b_tags [8];
      rst_n = 1'b1;
      lookup_valid = 1'b0; lookup_addr = '0; lookup_tag = '0;
      write_valid = 1'b0; write_addr = '0; write_way = '0; write_tag = '0; write_err = 1'b0;
      flush_valid = 1'b0;
      clear_model();
      #2 rst_n = 1'b0;
      repeat (2) cyc;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_init("init");

      // Everything misses after the power-on sweep
      do_lookup(5, 20'h12345);
      do_lookup(0, 20'h00000);

      do_write(3, 2, 20'hABCDE, 1'b0);
      do_lookup(3, 20'hABCDE);
      do_lookup(3, 20'hABCDF);
      do_write(5, 0, 20'h11111, 1'b1);
      do_lookup(5, 20'h11111);
      do_write(0, 1, 20'h00100, 1'b0);
      do_write(7, 3, 20'hFFFFF, 1'b1);
      do_write(6, 3, 20'h22222, 1'b0);
      do_write(6, 1, 20'h22222, 1'b1);
      do_lookup(6, 20'h22222);

      // Back-to-back lookups, one result per cycle
      b2b_tags[0] = 20'h00100; b2b_tags[1] = 20'h12345; b2b_tags[2] = 20'h00000; b2b_tags[3] = 20'hABCDE;
      b2b_tags[4] = 20'h00000; b2b_tags[5] = 20'h11111; b2b_tags[6] = 20'h22222; b2b_tags[7] = 20'hFFFFF;
      lookup_valid = 1'b1;
      for (int s = 0; s < 8; s++) begin
         lookup_addr = 3'(s);
         lookup_tag  = b2b_tags[s];
         sb.push_back(model_lookup(s, b2b_tags[s]));
         cyc;
         chk("b2b_valid", result_valid, 1);
      end
      lookup_valid = 1'b0;
      cyc;
      chk("b2b_drained", sb.size(), 0);

      // Flush beats write beats lookup; the other two stall through the sweep
      flush_valid = 1'b1;
      write_valid = 1'b1; write_addr = 3'd2; write_way = 2'd0; write_tag = 20'h33333; write_err = 1'b0;
      lookup_valid = 1'b1; lookup_addr = 3'd3; lookup_tag = 20'hABCDE;
      #1;
      chk("prio_flush_ready", flush_ready, 1);
      chk("prio_write_ready", write_ready, 0);
      chk("prio_lookup_ready", lookup_ready, 0);
      cyc;
      flush_valid = 1'b0;
      clear_model();
      for (int k = 1; k <= 8; k++) begin
         chk("flush_stall", {write_ready, lookup_ready, flush_ready}, 0);
         cyc;
         chk("flush_busy", busy, (k < 8));
      end
      chk("flush_write_ready", write_ready, 1);
      write_valid = 1'b0;
      lookup_valid = 1'b0;
      do_lookup(2, 20'h33333);
      do_lookup(3, 20'hABCDE);
      do_lookup(5, 20'h11111);
      do_lookup(0, 20'h00100);
      do_lookup(7, 20'hFFFFF);
      do_lookup(6, 20'h22222);

      // Reset in the middle of a flush sweep
      do_write(1, 3, 20'h55555, 1'b0);
      do_lookup(1, 20'h55555);
      flush_valid = 1'b1;
      cyc;
      flush_valid = 1'b0;
      repeat (4) cyc;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("flush_rst");
      clear_model();
      cyc;
      rst_n = 1'b1;
      wait_init("flush_rst_init");
      do_lookup(1, 20'h55555);

      // Reset while a result is pending drops it
      do_write(4, 2, 20'h0BEEF, 1'b1);
      lookup_valid = 1'b1; lookup_addr = 3'd4; lookup_tag = 20'h0BEEF;
      cyc;
      lookup_valid = 1'b0;
      chk("pend_valid", result_valid, 1);
      chk("pend_err", result_err, 1);
      rst_n = 1'b0;
      #1;
      chk("drop_valid", result_valid, 0);
      check_reset_outputs("lookup_rst");
      clear_model();
      cyc;
      rst_n = 1'b1;
      wait_init("lookup_rst_init");
      do_lookup(4, 20'h0BEEF);
      do_write(2, 1, 20'h7A7A7, 1'b0);
      do_lookup(2, 20'h7A7A7);

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
      begin
         res_t pe;
         do_write(4, 1, 20'h0F0F0, 1'b0);
         dut.g_way[1].i_way.i_sram.mem_q[4] = dut.g_way[1].i_way.i_sram.mem_q[4] ^ 23'h4;
         pe = '0;
         pe.perr = 1'b1;
         lookup_valid = 1'b1; lookup_addr = 3'd4; lookup_tag = 20'h0F0F0;
         sb.push_back(pe);
         cyc;
         lookup_valid = 1'b0;
      end
`endif

      cyc;
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
